// File: rtl/dds_sweep_ctrl.sv
// Frequency/phase word sequencer feeding the DDS core: fixed word, single sweep,
// sawtooth sweep or triangle sweep, each word held for a programmable dwell.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; configuration handshake accepted here
// S_HOLD | fixed mode, words held until abort
// S_RUN  | sweeping (modes 1-3), dwell counter paces each step
module dds_sweep_ctrl #(
    parameter int PHASE_WIDTH = 32,
    parameter int DWELL_WIDTH = 24
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [PHASE_WIDTH-1:0] cfg_start_word,
    input  logic [PHASE_WIDTH-1:0] cfg_stop_word,
    input  logic [PHASE_WIDTH-1:0] cfg_step_word,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [PHASE_WIDTH-1:0] cfg_pha_word,
    input  logic [1:0]             cfg_mode,
    input  logic                   start,
    input  logic                   abort,
    output logic [PHASE_WIDTH-1:0] fre_word,
    output logic [PHASE_WIDTH-1:0] pha_word,
    output logic                   busy,
    output logic                   step_strobe,
    output logic                   sweep_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_FIXED  = 2'd0;
    localparam logic [1:0] MODE_SINGLE = 2'd1;
    localparam logic [1:0] MODE_REPEAT = 2'd2;
    localparam logic [1:0] MODE_UPDOWN = 2'd3;

    localparam logic [PHASE_WIDTH-1:0] WORD_ONE  = {{(PHASE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] start_word_q, start_word_d;
    logic [PHASE_WIDTH-1:0] stop_word_q, stop_word_d;
    logic [PHASE_WIDTH-1:0] step_word_q, step_word_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [PHASE_WIDTH-1:0] pha_cfg_q, pha_cfg_d;
    logic [1:0]             mode_q, mode_d;
    logic [PHASE_WIDTH-1:0] fre_q, fre_d;
    logic [PHASE_WIDTH-1:0] pha_q, pha_d;
    logic                   busy_q, busy_d;
    logic                   strobe_q, strobe_d;
    logic                   done_q, done_d;
    logic                   dir_down_q, dir_down_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;

    logic                   cfg_fire;
    logic [PHASE_WIDTH-1:0] sel_start, sel_pha;
    logic [DWELL_WIDTH-1:0] sel_dwell_raw, sel_dwell;
    logic [1:0]             sel_mode;
    logic [DWELL_WIDTH-1:0] run_dwell;
    logic [PHASE_WIDTH-1:0] run_step;
    logic [PHASE_WIDTH:0]   up_sum, dn_diff;
    logic [PHASE_WIDTH-1:0] up_word, dn_word;
    logic                   at_stop, at_start, degenerate;

    assign cfg_fire = cfg_valid && (state_q == S_IDLE);

    // A handshake coinciding with start must feed the run directly, not wait for the shadows.
    assign sel_start     = cfg_fire ? cfg_start_word : start_word_q;
    assign sel_pha       = cfg_fire ? cfg_pha_word   : pha_cfg_q;
    assign sel_mode      = cfg_fire ? cfg_mode       : mode_q;
    assign sel_dwell_raw = cfg_fire ? cfg_dwell      : dwell_q;
    assign sel_dwell     = (sel_dwell_raw == '0) ? DWELL_ONE : sel_dwell_raw;

    assign run_dwell = (dwell_q == '0) ? DWELL_ONE : dwell_q;
    assign run_step  = (step_word_q == '0) ? WORD_ONE : step_word_q;

    // Extra bit catches overflow/borrow so the word clamps instead of wrapping.
    assign up_sum  = {1'b0, fre_q} + {1'b0, run_step};
    assign dn_diff = {1'b0, fre_q} - {1'b0, run_step};
    assign up_word = (up_sum >= {1'b0, stop_word_q}) ? stop_word_q : up_sum[PHASE_WIDTH-1:0];
    assign dn_word = (dn_diff[PHASE_WIDTH] || (dn_diff[PHASE_WIDTH-1:0] <= start_word_q))
                     ? start_word_q : dn_diff[PHASE_WIDTH-1:0];

    assign at_stop    = (fre_q >= stop_word_q);
    assign at_start   = (fre_q <= start_word_q);
    assign degenerate = (start_word_q >= stop_word_q);

    always_comb begin
        state_d      = state_q;
        start_word_d = start_word_q;
        stop_word_d  = stop_word_q;
        step_word_d  = step_word_q;
        dwell_d      = dwell_q;
        pha_cfg_d    = pha_cfg_q;
        mode_d       = mode_q;
        fre_d        = fre_q;
        pha_d        = pha_q;
        busy_d       = busy_q;
        strobe_d     = 1'b0;
        done_d       = 1'b0;
        dir_down_d   = dir_down_q;
        cnt_d        = cnt_q;

        if (cfg_fire) begin
            start_word_d = cfg_start_word;
            stop_word_d  = cfg_stop_word;
            step_word_d  = cfg_step_word;
            dwell_d      = cfg_dwell;
            pha_cfg_d    = cfg_pha_word;
            mode_d       = cfg_mode;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    fre_d      = sel_start;
                    pha_d      = sel_pha;
                    cnt_d      = sel_dwell;
                    dir_down_d = 1'b0;
                    busy_d     = 1'b1;
                    strobe_d   = 1'b1;
                    state_d    = (sel_mode == MODE_FIXED) ? S_HOLD : S_RUN;
                end
            end
            S_HOLD: state_d = S_HOLD;
            S_RUN: begin
                if (cnt_q <= DWELL_ONE) begin
                    cnt_d = run_dwell;
                    case (mode_q)
                        MODE_SINGLE: begin
                            if (at_stop) begin
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                                state_d = S_IDLE;
                            end else begin
                                fre_d    = up_word;
                                strobe_d = 1'b1;
                            end
                        end
                        MODE_REPEAT: begin
                            strobe_d = 1'b1;
                            if (at_stop) begin
                                fre_d  = start_word_q;
                                done_d = 1'b1;
                            end else begin
                                fre_d = up_word;
                            end
                        end
                        MODE_UPDOWN: begin
                            strobe_d = 1'b1;
                            if (degenerate) begin
                                fre_d  = start_word_q;
                                done_d = 1'b1;
                            end else if (!dir_down_q) begin
                                if (at_stop) begin
                                    dir_down_d = 1'b1;
                                    fre_d      = dn_word;
                                end else begin
                                    fre_d = up_word;
                                end
                            end else if (at_start) begin
                                done_d     = 1'b1;
                                dir_down_d = 1'b0;
                                fre_d      = up_word;
                            end else begin
                                fre_d = dn_word;
                            end
                        end
                        default: begin
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - DWELL_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d  = S_IDLE;
            fre_d    = '0;
            busy_d   = 1'b0;
            strobe_d = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            start_word_q <= '0;
            stop_word_q  <= '0;
            step_word_q  <= '0;
            dwell_q      <= '0;
            pha_cfg_q    <= '0;
            mode_q       <= '0;
            fre_q        <= '0;
            pha_q        <= '0;
            busy_q       <= 1'b0;
            strobe_q     <= 1'b0;
            done_q       <= 1'b0;
            dir_down_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            start_word_q <= start_word_d;
            stop_word_q  <= stop_word_d;
            step_word_q  <= step_word_d;
            dwell_q      <= dwell_d;
            pha_cfg_q    <= pha_cfg_d;
            mode_q       <= mode_d;
            fre_q        <= fre_d;
            pha_q        <= pha_d;
            busy_q       <= busy_d;
            strobe_q     <= strobe_d;
            done_q       <= done_d;
            dir_down_q   <= dir_down_d;
            cnt_q        <= cnt_d;
        end
    end

    assign cfg_ready   = (state_q == S_IDLE);
    assign fre_word    = fre_q;
    assign pha_word    = pha_q;
    assign busy        = busy_q;
    assign step_strobe = strobe_q;
    assign sweep_done  = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed and random sweeps compared cycle by cycle
// against a word-list model built from the sweep rules.
module tb_dds_sweep_ctrl;
    localparam int PW   = 32;
    localparam int DW   = 24;
    localparam int MAXC = 256;

    logic          clock = 1'b0;
    logic          reset, cfg_valid, start, abort;
    logic          cfg_ready;
    logic [PW-1:0] cfg_start_word, cfg_stop_word, cfg_step_word, cfg_pha_word;
    logic [DW-1:0] cfg_dwell;
    logic [1:0]    cfg_mode;
    logic [PW-1:0] fre_word, pha_word;
    logic          busy, step_strobe, sweep_done;

    int n_pass  = 0;
    int n_total = 0;

    logic [PW-1:0] exp_fre [MAXC];
    bit            exp_busy [MAXC];
    bit            exp_strobe [MAXC];
    bit            exp_done [MAXC];

    always #5 clock = ~clock;

    dds_sweep_ctrl #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_start_word(cfg_start_word), .cfg_stop_word(cfg_stop_word),
        .cfg_step_word(cfg_step_word), .cfg_dwell(cfg_dwell),
        .cfg_pha_word(cfg_pha_word), .cfg_mode(cfg_mode),
        .start(start), .abort(abort),
        .fre_word(fre_word), .pha_word(pha_word), .busy(busy),
        .step_strobe(step_strobe), .sweep_done(sweep_done)
    );

    // Expected per-cycle outputs from the visible word list of a run.
    task automatic model_build(input logic [31:0] st, input logic [31:0] sp,
                               input logic [31:0] stp, input logic [23:0] dw,
                               input logic [1:0] md, input int hor);
        longint s, e, k, w;
        int     d, c;
        bit     first, tail_done;
        longint up[$];
        longint dn[$];
        longint wq[$];
        bit     dq[$];
        s = {32'b0, st};
        e = {32'b0, sp};
        k = (stp == 0) ? 64'd1 : {32'b0, stp};
        d = (dw == 0) ? 1 : int'(dw);
        w = s;
        up.push_back(w);
        while (w < e) begin
            w = w + k;
            if (w > e) w = e;
            up.push_back(w);
        end
        if (s < e) begin
            w = e;
            while (w > s) begin
                w = w - k;
                if (w < s) w = s;
                dn.push_back(w);
            end
        end
        wq.push_back(s);
        dq.push_back(1'b0);
        if (md == 2'd1) begin
            for (int i = 1; i < up.size(); i++) begin
                wq.push_back(up[i]);
                dq.push_back(1'b0);
            end
        end else if (md != 2'd0) begin
            first = 1'b1;
            while (wq.size() * d < hor) begin
                if (s >= e) begin
                    wq.push_back(s);
                    dq.push_back(1'b1);
                end else if (md == 2'd2) begin
                    for (int i = 1; i < up.size(); i++) begin
                        wq.push_back(up[i]);
                        dq.push_back(1'b0);
                    end
                    wq.push_back(s);
                    dq.push_back(1'b1);
                end else begin
                    for (int i = 1; i < up.size(); i++) begin
                        wq.push_back(up[i]);
                        dq.push_back((i == 1) && !first);
                    end
                    foreach (dn[j]) begin
                        wq.push_back(dn[j]);
                        dq.push_back(1'b0);
                    end
                end
                first = 1'b0;
            end
        end
        c = 0;
        if (md == 2'd0) begin
            for (; c < hor; c++) begin
                exp_fre[c]    = st;
                exp_busy[c]   = 1'b1;
                exp_strobe[c] = (c == 0);
                exp_done[c]   = 1'b0;
            end
        end
        foreach (wq[j]) begin
            for (int r = 0; r < d; r++) begin
                if (c < hor) begin
                    w             = wq[j];
                    exp_fre[c]    = w[31:0];
                    exp_busy[c]   = 1'b1;
                    exp_strobe[c] = (r == 0);
                    exp_done[c]   = (r == 0) && dq[j];
                    c++;
                end
            end
        end
        tail_done = 1'b1;
        w = wq[wq.size()-1];
        for (; c < hor; c++) begin
            exp_fre[c]    = w[31:0];
            exp_busy[c]   = 1'b0;
            exp_strobe[c] = 1'b0;
            exp_done[c]   = tail_done;
            tail_done     = 1'b0;
        end
    endtask

    task automatic do_abort();
        @(posedge clock); #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
    endtask

    task automatic test_sweep_scenario(input string name, input logic [31:0] st,
                                       input logic [31:0] sp, input logic [31:0] stp,
                                       input logic [23:0] dw, input logic [31:0] ph,
                                       input logic [1:0] md, input int hor,
                                       input bit together, input int pulse_at);
        model_build(st, sp, stp, dw, md, hor);
        do_abort();
        cfg_start_word = st; cfg_stop_word = sp; cfg_step_word = stp;
        cfg_dwell = dw; cfg_pha_word = ph; cfg_mode = md;
        cfg_valid = 1'b1;
        if (!together) begin
            @(posedge clock); #1;
            cfg_valid = 1'b0;
            cfg_start_word = $urandom; cfg_stop_word = $urandom;
            cfg_pha_word = $urandom; cfg_mode = 2'($urandom);
        end
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cfg_valid = 1'b0;
        for (int i = 0; i < hor; i++) begin
            if (i > 0) begin
                @(posedge clock); #1;
            end
            if (i == pulse_at + 1) begin
                start = 1'b0;
                cfg_valid = 1'b0;
            end
            n_total++;
            if (fre_word !== exp_fre[i])
                $display("FAIL %s cyc %0d fre_word got %h exp %h", name, i, fre_word, exp_fre[i]);
            else n_pass++;
            n_total++;
            if (pha_word !== ph)
                $display("FAIL %s cyc %0d pha_word got %h exp %h", name, i, pha_word, ph);
            else n_pass++;
            n_total++;
            if (busy !== exp_busy[i])
                $display("FAIL %s cyc %0d busy got %b exp %b", name, i, busy, exp_busy[i]);
            else n_pass++;
            n_total++;
            if (cfg_ready !== !exp_busy[i])
                $display("FAIL %s cyc %0d cfg_ready got %b exp %b", name, i, cfg_ready, !exp_busy[i]);
            else n_pass++;
            n_total++;
            if (step_strobe !== exp_strobe[i])
                $display("FAIL %s cyc %0d step_strobe got %b exp %b", name, i, step_strobe, exp_strobe[i]);
            else n_pass++;
            n_total++;
            if (sweep_done !== exp_done[i])
                $display("FAIL %s cyc %0d sweep_done got %b exp %b", name, i, sweep_done, exp_done[i]);
            else n_pass++;
            if (i == pulse_at) begin
                start = 1'b1;
                cfg_valid = 1'b1;
                cfg_start_word = $urandom;
                cfg_mode = 2'($urandom);
            end
        end
        start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        n_total++;
        if (fre_word !== 32'h0 || pha_word !== 32'h0)
            $display("FAIL reset words got %h/%h exp 0/0", fre_word, pha_word);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || step_strobe !== 1'b0 || sweep_done !== 1'b0)
            $display("FAIL reset flags got %b%b%b exp 000", busy, step_strobe, sweep_done);
        else n_pass++;
        n_total++;
        if (cfg_ready !== 1'b1)
            $display("FAIL reset cfg_ready got %b exp 1", cfg_ready);
        else n_pass++;
    endtask

    task automatic test_basic_sweep();
        test_sweep_scenario("basic", 32'd100, 32'd400, 32'd100, 24'd3, 32'h1234, 2'd1, 16, 1'b0, 4);
    endtask

    task automatic test_clamp();
        test_sweep_scenario("clamp_hi", 32'hF0000000, 32'hFFFFFFFF, 32'h20000000, 24'd1,
                            32'h5, 2'd1, 5, 1'b1, -1);
        test_sweep_scenario("clamp_mid", 32'h0, 32'h80000000, 32'h30000000, 24'd1,
                            32'h6, 2'd1, 7, 1'b0, -1);
    endtask

    task automatic test_modes_2_3();
        test_sweep_scenario("mode2", 32'd1, 32'd3, 32'd1, 24'd2, 32'h77, 2'd2, 30, 1'b1, 3);
        test_sweep_scenario("mode3", 32'd1, 32'd3, 32'd1, 24'd2, 32'h88, 2'd3, 30, 1'b0, 3);
        test_sweep_scenario("degen2", 32'd9, 32'd5, 32'd1, 24'd3, 32'h1, 2'd2, 12, 1'b1, -1);
        test_sweep_scenario("degen3", 32'd5, 32'd5, 32'd0, 24'd0, 32'h2, 2'd3, 8, 1'b0, -1);
        test_sweep_scenario("degen1", 32'd9, 32'd5, 32'd1, 24'd2, 32'h3, 2'd1, 6, 1'b1, -1);
    endtask

    task automatic test_fixed_abort();
        test_sweep_scenario("fixed", 32'h0D49FB83, 32'h0, 32'h1, 24'd2, 32'h40000000, 2'd0, 40, 1'b1, 5);
        @(posedge clock); #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        n_total++;
        if (fre_word !== 32'h0)
            $display("FAIL abort fre_word got %h exp 0", fre_word);
        else n_pass++;
        n_total++;
        if (pha_word !== 32'h40000000)
            $display("FAIL abort pha_word got %h exp 40000000", pha_word);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1)
            $display("FAIL abort busy/cfg_ready got %b/%b exp 0/1", busy, cfg_ready);
        else n_pass++;
    endtask

    task automatic test_handshake();
        do_abort();
        cfg_start_word = 32'd500; cfg_stop_word = 32'd900; cfg_step_word = 32'd10;
        cfg_dwell = 24'd4; cfg_pha_word = 32'hAA; cfg_mode = 2'd0;
        cfg_valid = 1'b1;
        @(posedge clock); #1;
        cfg_start_word = 32'd777; cfg_pha_word = 32'hBB;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; cfg_valid = 1'b0;
        n_total++;
        if (fre_word !== 32'd777 || pha_word !== 32'hBB)
            $display("FAIL cfg_with_start words got %0d/%h exp 777/bb", fre_word, pha_word);
        else n_pass++;
        n_total++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0)
            $display("FAIL cfg_with_start busy/cfg_ready got %b/%b exp 1/0", busy, cfg_ready);
        else n_pass++;
        do_abort();
        start = 1'b1; abort = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0;
        n_total++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || fre_word !== 32'h0 || step_strobe !== 1'b0)
            $display("FAIL start_abort got busy %b ready %b fre %h strobe %b exp 0 1 0 0",
                     busy, cfg_ready, fre_word, step_strobe);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_abort();
        cfg_start_word = 32'd100; cfg_stop_word = 32'd400; cfg_step_word = 32'd100;
        cfg_dwell = 24'd3; cfg_pha_word = 32'hCAFE; cfg_mode = 2'd1;
        cfg_valid = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        cfg_valid = 1'b0; start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        n_total++;
        if (fre_word !== 32'd200)
            $display("FAIL reset_mid pre fre_word got %0d exp 200", fre_word);
        else n_pass++;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        n_total++;
        if (fre_word !== 32'h0 || pha_word !== 32'h0 || busy !== 1'b0 ||
            step_strobe !== 1'b0 || sweep_done !== 1'b0)
            $display("FAIL reset_mid outputs got %h %h %b%b%b exp all 0",
                     fre_word, pha_word, busy, step_strobe, sweep_done);
        else n_pass++;
        n_total++;
        if (cfg_ready !== 1'b1)
            $display("FAIL reset_mid cfg_ready got %b exp 1", cfg_ready);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] base, st, sp, stp;
        for (int n = 0; n < 20; n++) begin
            base = ($urandom_range(0, 3) == 0) ? 32'hFFFFF800 : 32'h0;
            st   = base + $urandom_range(0, 32'h7FF);
            sp   = base + $urandom_range(0, 32'h7FF);
            stp  = $urandom_range(0, 32'h400);
            test_sweep_scenario("random", st, sp, stp, 24'($urandom_range(0, 4)), $urandom,
                                2'($urandom_range(0, 3)), 60, 1'($urandom_range(0, 1)), -1);
        end
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_start_word = '0; cfg_stop_word = '0; cfg_step_word = '0;
        cfg_dwell = '0; cfg_pha_word = '0; cfg_mode = '0;
        test_reset();
        test_basic_sweep();
        test_clamp();
        test_modes_2_3();
        test_fixed_abort();
        test_handshake();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency and phase control stage placed directly upstream of the DDS core. It accepts a sweep configuration over a valid/ready handshake. On `start`, it drives the DDS `fre_word` and `pha_word` inputs through one of four modes: fixed word, single linear sweep, repeating sawtooth sweep, or up/down triangle sweep. Each frequency word is held for a programmable dwell before the next step.

## Interface
- `PHASE_WIDTH`, default 32: width of the frequency and phase words; matches the DDS core.
- `DWELL_WIDTH`, default 24: width of the dwell counter.

- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `cfg_valid`  in  1  configuration presented
- `cfg_ready`  out  1  high only in IDLE
- `cfg_start_word`  in  PHASE_WIDTH  first frequency word
- `cfg_stop_word`  in  PHASE_WIDTH  final frequency word
- `cfg_step_word`  in  PHASE_WIDTH  increment per step; 0 is treated as 1
- `cfg_dwell`  in  DWELL_WIDTH  cycles each word is held; 0 is treated as 1
- `cfg_pha_word`  in  PHASE_WIDTH  phase offset, constant for the whole run
- `cfg_mode`  in  2  0 fixed, 1 single sweep, 2 repeat sweep, 3 up/down
- `start`  in  1  one-cycle pulse; starts a run from IDLE
- `abort`  in  1  one-cycle pulse; ends any run
- `fre_word`  out  PHASE_WIDTH  to the DDS core, registered
- `pha_word`  out  PHASE_WIDTH  to the DDS core, registered
- `busy`  out  1  high in HOLD or RUN
- `step_strobe`  out  1  high on the first cycle each new word is visible
- `sweep_done`  out  1  one-cycle end-of-sweep pulse

## Operation
- **States:** IDLE, HOLD (mode 0) and RUN (modes 1–3).
- **Reset:** state IDLE. `fre_word`, `pha_word`, `busy`, `step_strobe`, `sweep_done`, the shadow registers and the direction bit all clear to 0. `cfg_ready` is 1.
- **Configuration capture:** on `cfg_valid && cfg_ready`, the shadow registers capture all `cfg_*` fields. The outputs are unchanged until `start`.
- **Start:** `start` in IDLE loads `fre_word` with the start word and `pha_word` with the phase word. It also loads the dwell counter with D = max(dwell, 1) and sets direction to up. The next state is HOLD for mode 0 and RUN otherwise.
- **Config and start together:** if `start` and a configuration handshake occur in the same cycle, the run uses the newly presented configuration.
- **Start while busy:** ignored.
- **HOLD:** the words stay constant until `abort`.
- **RUN, dwell:** the counter decrements every cycle. When it expires, the block steps to the next word and reloads D.
- **RUN, step up:** next = fre + step, computed at PHASE_WIDTH+1 bits. If next ≥ stop, `fre_word` becomes stop (clamped, never wraps).
- **RUN, step down (mode 3):** next = fre − step, with borrow. If next ≤ start, `fre_word` becomes start.
- **End of dwell on the stop word:**
  - Mode 1: pulse `sweep_done`, go to IDLE; `fre_word` keeps the stop word.
  - Mode 2: load the start word and pulse `sweep_done` and `step_strobe` in the same cycle.
  - Mode 3: set direction down and step down; the stop word is not repeated.
- **End of dwell on the start word while stepping down (mode 3):** pulse `sweep_done`, set direction up and step up.
- **Degenerate range (start ≥ stop):** only the start word is used. Mode 1 finishes after one dwell. Modes 2 and 3 repeat the start word, pulsing `sweep_done` every D cycles.
- **Abort:** from any state, the next state is IDLE and `fre_word` is forced to 0; `pha_word` holds. `abort` wins over a simultaneous `start`.
- **Reset mid-run:** immediate return to the reset values listed above.

## Timing
- All outputs are registered. `cfg_ready` is decoded from the state register.
- **Start latency:** `start` sampled at edge N makes the start word visible after edge N. `busy` and `step_strobe` are high in the same cycle.
- **Word hold:** each word is visible for exactly D cycles. The next word appears after D edges.
- **`sweep_done` in mode 1:** appears in the cycle after the stop word's final dwell cycle, in the same cycle `busy` falls.
- **Abort latency:** `abort` at edge N gives `busy`=0 and `fre_word`=0 after edge N.
- A new `start` is accepted in the first IDLE cycle.

## Test plan
- **Basic single sweep:** mode 1, start 100, stop 400, step 100, dwell 3.
  - Expect `fre_word` 100, 200, 300, 400, each for 3 cycles, with 4 `step_strobe` pulses.
  - `sweep_done` 12 cycles after the first word; `fre_word` stays 400 and `busy` is 0.
- **Clamp and overflow:** start 0xF0000000, stop 0xFFFFFFFF, step 0x20000000, dwell 1.
  - Expect 0xF0000000 then 0xFFFFFFFF with no wrap.
  - Repeat with start 0, stop 0x80000000, step 0x30000000: expect 0, 0x30000000, 0x60000000, 0x80000000.
- **Mode 2 and mode 3 sequences:** start 1, stop 3, step 1, dwell 2.
  - Mode 2: 1, 2, 3, 1, 2, 3…, with `sweep_done` at each return to 1.
  - Mode 3: 1, 2, 3, 2, 1, 2…, with `sweep_done` at each return to 1.
- **Fixed mode and abort:** mode 0 with start 0x0D49FB83 and phase 0x40000000.
  - The words hold indefinitely.
  - Abort gives `fre_word`=0, `pha_word`=0x40000000, `busy`=0 next cycle.
- **Handshake corner cases:**
  - `start` and `cfg_valid` in the same cycle: the new start word is used.
  - `start` during RUN: ignored.
  - `start` and `abort` together: the block stays IDLE.
  - `cfg_ready` is 0 throughout RUN.
- **Reset mid-sweep:** assert `reset` in cycle 5 of a mode 1 run. All outputs read 0 and `cfg_ready` reads 1 the next cycle.
